// File: rtl/cac3c_codec_iter.sv
// Iterative 3C-free (no 010/101) TSV codec: Fibonacci-weighted encode/decode, one bit per cycle.
// Latency N_TSV cycles from accept to out_valid; single request in flight, result held until out_ready.
module cac3c_codec_iter #(
  parameter int N_TSV = 23,
  parameter int DW    = 17
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [DW-1:0]    in_value,
  input  logic [N_TSV-1:0] in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_op,
  output logic [N_TSV-1:0] out_code,
  output logic [DW-1:0]    out_value,
  output logic             out_err
);

  function automatic longint fib(input int m);
    longint a, b, t;
    a = 1;
    b = 2;
    if (m == 0) return 1;
    for (int i = 2; i <= m; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  localparam longint CAP = 2 * fib(N_TSV - 1);
  localparam int PW = $clog2(N_TSV);
  localparam logic [DW:0] CAP_W = (DW + 1)'(CAP);

  if (N_TSV < 3 || N_TSV > 40) begin : g_bad_n
    $error("N_TSV must be within 3..40");
  end
  if ((longint'(1) << DW) < CAP) begin : g_bad_dw
    $error("DW too narrow for codeword capacity");
  end

  logic [DW:0] wtab [N_TSV];
  for (genvar g = 0; g < N_TSV; g++) begin : g_w
    assign wtab[g] = (DW + 1)'(fib(g));
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;

  logic             op_q, first, forced, prev, err;
  logic [PW-1:0]    pos;
  logic [DW:0]      resid;
  logic [N_TSV-1:0] sr;

  logic        bit_n, forced_n, err_n, ge;
  logic [DW:0] resid_n, w;

  // resid holds the encode residual or the decode accumulator; sr rotates the codeword on decode
  always_comb begin
    w        = wtab[pos];
    ge       = resid >= w;
    bit_n    = prev;
    resid_n  = resid;
    forced_n = 1'b0;
    err_n    = err;
    if (!op_q) begin
      if (first) begin
        bit_n = ge;
        if (ge) resid_n = resid - w;
      end else if (!forced && ge) begin
        bit_n    = ~prev;
        resid_n  = resid - w;
        forced_n = 1'b1;
      end
    end else begin
      bit_n = sr[N_TSV-1];
      if (first) begin
        if (bit_n) resid_n = resid + w;
      end else if (forced) begin
        if (bit_n != prev) err_n = 1'b1;
      end else if (bit_n != prev) begin
        resid_n  = resid + w;
        forced_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_op    <= 1'b0;
      out_code  <= '0;
      out_value <= '0;
      out_err   <= 1'b0;
      op_q      <= 1'b0;
      first     <= 1'b0;
      forced    <= 1'b0;
      prev      <= 1'b0;
      err       <= 1'b0;
      pos       <= '0;
      resid     <= '0;
      sr        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= BUSY;
            in_ready <= 1'b0;
            op_q     <= in_op;
            pos      <= PW'(N_TSV - 1);
            first    <= 1'b1;
            forced   <= 1'b0;
            prev     <= 1'b0;
            if (in_op) begin
              resid <= '0;
              sr    <= in_code;
              err   <= 1'b0;
            end else begin
              resid <= {1'b0, in_value};
              sr    <= '0;
              err   <= {1'b0, in_value} >= CAP_W;
            end
          end
        end
        BUSY: begin
          first  <= 1'b0;
          forced <= forced_n;
          prev   <= bit_n;
          resid  <= resid_n;
          err    <= err_n;
          sr     <= {sr[N_TSV-2:0], bit_n};
          pos    <= pos - PW'(1);
          if (pos == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_op    <= op_q;
            out_err   <= err_n;
            if (op_q) begin
              out_code  <= '0;
              out_value <= err_n ? '0 : resid_n[DW-1:0];
            end else begin
              out_value <= '0;
              out_code  <= err_n ? '0 : {sr[N_TSV-2:0], bit_n};
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cac3c_codec_iter.sv
// Directed and round-trip bench for cac3c_codec_iter at N_TSV = 23, 4 and 8.
module tb_cac3c_codec_iter;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic rst_n;

  logic        iv [3], iop [3], ordy [3];
  logic [31:0] ival [3];
  logic [39:0] icode [3];
  logic        ir [3], ovld [3], oop [3], oerr [3];
  logic [39:0] ocode [3];
  logic [31:0] oval [3];

  logic [22:0] oc0; logic [16:0] ovv0;
  logic [3:0]  oc1; logic [3:0]  ovv1;
  logic [7:0]  oc2; logic [6:0]  ovv2;
  assign ocode[0] = {17'b0, oc0}; assign oval[0] = {15'b0, ovv0};
  assign ocode[1] = {36'b0, oc1}; assign oval[1] = {28'b0, ovv1};
  assign ocode[2] = {32'b0, oc2}; assign oval[2] = {25'b0, ovv2};

  cac3c_codec_iter #(.N_TSV(23), .DW(17)) u23 (
    .clock(clock), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_op(iop[0]),
    .in_value(ival[0][16:0]), .in_code(icode[0][22:0]), .out_valid(ovld[0]), .out_ready(ordy[0]),
    .out_op(oop[0]), .out_code(oc0), .out_value(ovv0), .out_err(oerr[0]));
  cac3c_codec_iter #(.N_TSV(4), .DW(4)) u4 (
    .clock(clock), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_op(iop[1]),
    .in_value(ival[1][3:0]), .in_code(icode[1][3:0]), .out_valid(ovld[1]), .out_ready(ordy[1]),
    .out_op(oop[1]), .out_code(oc1), .out_value(ovv1), .out_err(oerr[1]));
  cac3c_codec_iter #(.N_TSV(8), .DW(7)) u8 (
    .clock(clock), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_op(iop[2]),
    .in_value(ival[2][6:0]), .in_code(icode[2][7:0]), .out_valid(ovld[2]), .out_ready(ordy[2]),
    .out_op(oop[2]), .out_code(oc2), .out_value(ovv2), .out_err(oerr[2]));

  int errors = 0;
  int checks = 0;

  function automatic int nt(input int d);
    return (d == 0) ? 23 : (d == 1) ? 4 : 8;
  endfunction

  function automatic bit has3c(input logic [39:0] c, input int n);
    for (int i = 0; i + 2 < n; i++)
      if (c[i+:3] == 3'b010 || c[i+:3] == 3'b101) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input int d);
    int n;
    n = 0;
    while (ir[d] !== 1'b1 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk("ready_timeout", 64'(n < 200), 64'd1);
  endtask

  task automatic req(input int d, input bit op, input logic [31:0] val, input logic [39:0] code,
                     output logic [39:0] rc, output logic [31:0] rv, output bit re,
                     output bit rop, output int lat);
    wait_ready(d);
    iop[d] = op; ival[d] = val; icode[d] = code; iv[d] = 1'b1;
    @(posedge clock); #1;
    iv[d] = 1'b0;
    lat = 0;
    while (ovld[d] !== 1'b1 && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    rc = ocode[d]; rv = oval[d]; re = oerr[d]; rop = oop[d];
    ordy[d] = 1'b1;
    @(posedge clock); #1;
    ordy[d] = 1'b0;
  endtask

  typedef struct {
    int          d;
    bit          op;
    logic [31:0] val;
    logic [39:0] code;
    logic [39:0] ecode;
    logic [31:0] evalue;
    bit          eerr;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [39:0] rc;
    logic [31:0] rv;
    bit re, rop;
    int lat;
    logic [31:0] x;

    tbl[0]  = '{0, 1'b0, 32'd0,     40'd0, 40'd0, 32'd0, 1'b0};
    tbl[1]  = '{0, 1'b0, 32'd92735, 40'd0, 40'b10011001100110011001100, 32'd0, 1'b0};
    tbl[2]  = '{0, 1'b1, 32'd0, 40'b10011001100110011001100, 40'd0, 32'd92735, 1'b0};
    tbl[3]  = '{1, 1'b0, 32'd3,  40'd0, 40'b0111, 32'd0, 1'b0};
    tbl[4]  = '{1, 1'b0, 32'd9,  40'd0, 40'b1001, 32'd0, 1'b0};
    tbl[5]  = '{1, 1'b0, 32'd10, 40'd0, 40'd0,    32'd0, 1'b1};
    tbl[6]  = '{1, 1'b1, 32'd0, 40'b0100, 40'd0, 32'd0, 1'b1};
    tbl[7]  = '{1, 1'b1, 32'd0, 40'b0011, 40'd0, 32'd2, 1'b0};
    tbl[8]  = '{1, 1'b1, 32'd0, 40'b1001, 40'd0, 32'd9, 1'b0};
    tbl[9]  = '{2, 1'b0, 32'd67, 40'd0, 40'b10011001, 32'd0, 1'b0};
    tbl[10] = '{2, 1'b0, 32'd68, 40'd0, 40'd0, 32'd0, 1'b1};
    tbl[11] = '{1, 1'b1, 32'd0, 40'b1111, 40'd0, 32'd5, 1'b0};
    tbl[12] = '{1, 1'b0, 32'd1, 40'd0, 40'b0001, 32'd0, 1'b0};
    tbl[13] = '{1, 1'b1, 32'd0, 40'b1010, 40'd0, 32'd0, 1'b1};
    tbl[14] = '{0, 1'b0, 32'd92736, 40'd0, 40'd0, 32'd0, 1'b1};

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; iop[d] = 1'b0; ival[d] = '0; icode[d] = '0; ordy[d] = 1'b0;
    end
    repeat (3) @(posedge clock);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_in_ready", 64'(ir[d]), 64'd1);
      chk("rst_out_valid", 64'(ovld[d]), 64'd0);
      chk("rst_outputs", {22'd0, oop[d], oerr[d], ocode[d]} | 64'(oval[d]), 64'd0);
    end
    @(negedge clock) rst_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 15; i++) begin
      req(tbl[i].d, tbl[i].op, tbl[i].val, tbl[i].code, rc, rv, re, rop, lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(nt(tbl[i].d)));
      chk($sformatf("v%0d_op", i), 64'(rop), 64'(tbl[i].op));
      chk($sformatf("v%0d_code", i), 64'(rc), 64'(tbl[i].ecode));
      chk($sformatf("v%0d_value", i), 64'(rv), 64'(tbl[i].evalue));
      chk($sformatf("v%0d_err", i), 64'(re), 64'(tbl[i].eerr));
    end

    // Result must hold while the consumer stalls, and a new request must be ignored.
    wait_ready(1);
    iop[1] = 1'b0; ival[1] = 32'd9; iv[1] = 1'b1;
    @(posedge clock); #1;
    iv[1] = 1'b0;
    lat = 0;
    while (ovld[1] !== 1'b1 && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    iop[1] = 1'b1; icode[1] = 40'b0011; iv[1] = 1'b1;
    repeat (5) begin
      @(posedge clock); #1;
      chk("stall_valid", 64'(ovld[1]), 64'd1);
      chk("stall_code", 64'(ocode[1]), 64'b1001);
      chk("stall_in_ready", 64'(ir[1]), 64'd0);
    end
    ordy[1] = 1'b1;
    @(posedge clock); #1;
    ordy[1] = 1'b0; iv[1] = 1'b0;
    chk("release_in_ready", 64'(ir[1]), 64'd1);
    chk("release_valid", 64'(ovld[1]), 64'd0);
    @(posedge clock); #1;
    chk("ignored_req_idle", 64'(ir[1]), 64'd1);

    // Asynchronous reset while busy clears outputs left by the previous decode.
    req(0, 1'b1, 32'd0, 40'b10011001100110011001100, rc, rv, re, rop, lat);
    wait_ready(0);
    iop[0] = 1'b0; ival[0] = 32'd92735; iv[0] = 1'b1;
    @(posedge clock); #1;
    iv[0] = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock) rst_n = 1'b0;
    #1;
    chk("midrst_out_op", 64'(oop[0]), 64'd0);
    chk("midrst_out_value", 64'(oval[0]), 64'd0);
    chk("midrst_out_code", 64'(ocode[0]), 64'd0);
    chk("midrst_valid_err", {ovld[0], oerr[0]}, 64'd0);
    chk("midrst_in_ready", 64'(ir[0]), 64'd1);
    @(negedge clock) rst_n = 1'b1;
    req(0, 1'b0, 32'd92735, 40'd0, rc, rv, re, rop, lat);
    chk("post_rst_code", 64'(rc), 64'b10011001100110011001100);
    chk("post_rst_latency", 64'(lat), 64'd23);

    // Round trips with the 3C property checked on every encoded word.
    for (int k = 0; k < 90; k++) begin
      int d;
      d = (k < 60) ? 2 : 0;
      x = (d == 2) ? $urandom_range(0, 67) : $urandom_range(0, 92735);
      req(d, 1'b0, x, 40'd0, rc, rv, re, rop, lat);
      chk("rt_enc_err", 64'(re), 64'd0);
      chk("rt_no_3c", 64'(has3c(rc, nt(d))), 64'd0);
      req(d, 1'b1, 32'd0, rc, rc, rv, re, rop, lat);
      chk("rt_dec_value", 64'(rv), 64'(x));
      chk("rt_dec_err", 64'(re), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
